// File: rtl/dcache_port_arbiter.sv
// Two-requester round-robin arbiter in front of the single DCache req/ack port.
// One transaction in flight; optional watchdog forces completion of a hung access.
module dcache_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_op,
    input  logic [3:0]        i_m0_bytes,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_op,
    input  logic [3:0]        i_m1_bytes,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_dcache_req,
    output logic [ADDR_W-1:0] o_dcache_addr,
    output logic              o_dcache_op,
    output logic [3:0]        o_dcache_bytes,
    output logic [DATA_W-1:0] o_dcache_wdata,
    input  logic              i_dcache_ack,
    input  logic [DATA_W-1:0] i_dcache_rdata,
    output logic              o_timeout,
    output logic [1:0]        o_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } state_t;

    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_t            state_r;
    state_t            state_s;
    logic              prio_r;
    logic [CNT_W-1:0]  wd_cnt_r;
    logic              busy_s;
    logic              timeout_s;
    logic              done_s;
    logic              grant0_s;
    logic              grant1_s;

    // prio_r==0 favours port 0 on a tie, prio_r==1 favours port 1
    assign grant0_s  = i_m0_req & (~i_m1_req | ~prio_r);
    assign grant1_s  = i_m1_req & (~i_m0_req | prio_r);
    assign busy_s    = (state_r == ST_BUSY0) || (state_r == ST_BUSY1);
    assign timeout_s = WD_EN && busy_s && !i_dcache_ack && (wd_cnt_r == TO_LIM);
    assign done_s    = busy_s && (i_dcache_ack || timeout_s);
    assign o_owner   = state_r;

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant0_s) begin
                    state_s = ST_BUSY0;
                end else if (grant1_s) begin
                    state_s = ST_BUSY1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Completion routing: only the owner sees ack; timeout completions return zero data
    always_comb begin
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_rdata = '0;
        o_m1_rdata = '0;
        o_timeout  = timeout_s;
        if (state_r == ST_BUSY0) begin
            o_m0_ack   = done_s;
            o_m0_rdata = i_dcache_ack ? i_dcache_rdata : '0;
        end else if (state_r == ST_BUSY1) begin
            o_m1_ack   = done_s;
            o_m1_rdata = i_dcache_ack ? i_dcache_rdata : '0;
        end else begin
            o_m0_ack   = 1'b0;
            o_m1_ack   = 1'b0;
        end
    end

    // State and round-robin priority registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            prio_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (done_s) begin
                prio_r <= (state_r == ST_BUSY0);
            end else begin
                prio_r <= prio_r;
            end
        end
    end

    // DCache request registers, latched from the winner on grant and held while busy
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_dcache_req   <= 1'b0;
            o_dcache_addr  <= '0;
            o_dcache_op    <= 1'b0;
            o_dcache_bytes <= 4'd0;
            o_dcache_wdata <= '0;
        end else if (state_r == ST_IDLE) begin
            o_dcache_req <= grant0_s | grant1_s;
            if (grant0_s) begin
                o_dcache_addr  <= i_m0_addr;
                o_dcache_op    <= i_m0_op;
                o_dcache_bytes <= i_m0_bytes;
                o_dcache_wdata <= i_m0_wdata;
            end else if (grant1_s) begin
                o_dcache_addr  <= i_m1_addr;
                o_dcache_op    <= i_m1_op;
                o_dcache_bytes <= i_m1_bytes;
                o_dcache_wdata <= i_m1_wdata;
            end
        end else if (done_s) begin
            o_dcache_req <= 1'b0;
        end
    end

    // Watchdog: zero on entry to busy, counts busy cycles without completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_r <= '0;
        end else if (!WD_EN || !busy_s || done_s) begin
            wd_cnt_r <= '0;
        end else begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed and randomized bench for dcache_port_arbiter against a cycle-level
// transaction model (owner, busy age, priority) kept in plain integers.
module tb_dcache_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_op, m1_req, m1_op;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_bytes, m1_bytes;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          o_m0_ack, o_m1_ack;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata;
    logic          o_dcache_req, o_dcache_op;
    logic [AW-1:0] o_dcache_addr;
    logic [3:0]    o_dcache_bytes;
    logic [DW-1:0] o_dcache_wdata;
    logic          dc_ack;
    logic [DW-1:0] dc_rdata;
    logic          o_timeout;
    logic [1:0]    o_owner;

    dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_op(m0_op), .i_m0_bytes(m0_bytes),
        .i_m0_wdata(m0_wdata), .o_m0_ack(o_m0_ack), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_op(m1_op), .i_m1_bytes(m1_bytes),
        .i_m1_wdata(m1_wdata), .o_m1_ack(o_m1_ack), .o_m1_rdata(o_m1_rdata),
        .o_dcache_req(o_dcache_req), .o_dcache_addr(o_dcache_addr), .o_dcache_op(o_dcache_op),
        .o_dcache_bytes(o_dcache_bytes), .o_dcache_wdata(o_dcache_wdata),
        .i_dcache_ack(dc_ack), .i_dcache_rdata(dc_rdata),
        .o_timeout(o_timeout), .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: owner 0=none,1=port0,2=port1; age = busy cycles already elapsed
    int            m_owner = 0, m_prio = 0, m_age = 0;
    logic [AW-1:0] m_addr  = '0;
    logic          m_op    = 1'b0;
    logic [3:0]    m_bytes = 4'd0;
    logic [DW-1:0] m_wdata = '0;

    // observations
    int            ack0_cnt = 0, ack1_cnt = 0, to_cnt = 0;
    logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
    bit            saw_ack0, saw_ack1;
    int            grant_q[$];
    logic [1:0]    prev_owner = 2'b00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit busy, to, fin;
        logic [63:0] e0, e1;
        @(negedge clk);
        busy = (m_owner != 0);
        to   = busy && !dc_ack && (m_age == TO - 1);
        fin  = busy && (dc_ack || to);
        e0   = (m_owner == 1 && dc_ack) ? dc_rdata : 64'd0;
        e1   = (m_owner == 2 && dc_ack) ? dc_rdata : 64'd0;
        chk("m0_ack", o_m0_ack, 64'(m_owner == 1 && fin));
        chk("m1_ack", o_m1_ack, 64'(m_owner == 2 && fin));
        chk("m0_rdata", o_m0_rdata, e0);
        chk("m1_rdata", o_m1_rdata, e1);
        chk("timeout", o_timeout, 64'(to));
        chk("owner", o_owner, 64'(m_owner));
        chk("dc_req", o_dcache_req, 64'(busy));
        if (busy) begin
            chk("dc_addr", o_dcache_addr, m_addr);
            chk("dc_op", o_dcache_op, 64'(m_op));
            chk("dc_bytes", o_dcache_bytes, 64'(m_bytes));
            chk("dc_wdata", o_dcache_wdata, m_wdata);
        end
        saw_ack0 = o_m0_ack;
        saw_ack1 = o_m1_ack;
        if (o_m0_ack) begin ack0_cnt++; last_rd0 = o_m0_rdata; end
        if (o_m1_ack) begin ack1_cnt++; last_rd1 = o_m1_rdata; end
        if (o_timeout) to_cnt++;
        if (o_owner != 2'b00 && prev_owner == 2'b00) grant_q.push_back(int'(o_owner));
        prev_owner = o_owner;
        @(posedge clk);
        if (!rst) begin
            m_owner = 0; m_prio = 0; m_age = 0;
        end else if (!busy) begin
            if (m0_req && (!m1_req || m_prio == 0)) begin
                m_owner = 1; m_age = 0;
                m_addr = m0_addr; m_op = m0_op; m_bytes = m0_bytes; m_wdata = m0_wdata;
            end else if (m1_req) begin
                m_owner = 2; m_age = 0;
                m_addr = m1_addr; m_op = m1_op; m_bytes = m1_bytes; m_wdata = m1_wdata;
            end
        end else if (fin) begin
            m_prio  = (m_owner == 1) ? 1 : 0;
            m_owner = 0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int a0, a1, tc;
        logic [DW-1:0] wd;
        rst = 1'b0; dc_ack = 1'b0; dc_rdata = '0;
        m0_req = 1'b0; m0_addr = '0; m0_op = 1'b0; m0_bytes = 4'd0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_op = 1'b0; m1_bytes = 4'd0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        ticks(1);
        chk("rst_addr", o_dcache_addr, 64'd0);
        chk("rst_wdata", o_dcache_wdata, 64'd0);
        chk("rst_bytes", o_dcache_bytes, 64'd0);
        rst = 1'b1;
        dc_ack = 1'b1; dc_rdata = 64'hAAAA_5555_AAAA_5555;
        ticks(1);                                // stale ack in idle
        chk("stale_ack0", 64'(ack0_cnt), 64'd0);
        dc_ack = 1'b0;

        // single read on port 0
        a1 = ack1_cnt;
        m0_req = 1'b1; m0_addr = 64'h8000_0010; m0_op = 1'b0; m0_bytes = 4'd8;
        ticks(1);
        chk("t1_addr", o_dcache_addr, 64'h8000_0010);
        ticks(1);
        dc_ack = 1'b1; dc_rdata = 64'hDEAD_BEEF_0123_4567;
        ticks(1);
        m0_req = 1'b0; dc_ack = 1'b0;
        ticks(2);
        chk("t1_ack0_cnt", 64'(ack0_cnt), 64'd1);
        chk("t1_rdata", last_rd0, 64'hDEAD_BEEF_0123_4567);
        chk("t1_no_ack1", 64'(ack1_cnt - a1), 64'd0);

        // simultaneous requests after reset: 0,1,0,1
        rst = 1'b0; ticks(1); rst = 1'b1;
        grant_q.delete();
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 64'h40; dc_ack = 1'b1; dc_rdata = 64'h77;
        ticks(8);
        m0_req = 1'b0; m1_req = 1'b0; dc_ack = 1'b0;
        ticks(2);
        chk("rr_count", 64'(grant_q.size()), 64'd4);
        chk("rr_g0", 64'(grant_q[0]), 64'd1);
        chk("rr_g1", 64'(grant_q[1]), 64'd2);
        chk("rr_g2", 64'(grant_q[2]), 64'd1);
        chk("rr_g3", 64'(grant_q[3]), 64'd2);

        // write routing on port 1, inputs change mid-transaction
        a0 = ack0_cnt; a1 = ack1_cnt;
        wd = 64'h1122_3344_5566_7788;
        m1_req = 1'b1; m1_addr = 64'h8000_0100; m1_op = 1'b1; m1_bytes = 4'd4; m1_wdata = wd;
        ticks(1);
        m1_addr = 64'hFFFF_0000; m1_op = 1'b0; m1_bytes = 4'd1; m1_wdata = 64'h0BAD;
        ticks(1);
        chk("wr_wdata", o_dcache_wdata, wd);
        chk("wr_op", o_dcache_op, 64'd1);
        chk("wr_bytes", o_dcache_bytes, 64'd4);
        chk("wr_addr", o_dcache_addr, 64'h8000_0100);
        dc_ack = 1'b1; dc_rdata = 64'h5A5A;
        ticks(1);
        m1_req = 1'b0; dc_ack = 1'b0;
        ticks(1);
        chk("wr_ack1", 64'(ack1_cnt - a1), 64'd1);
        chk("wr_no_ack0", 64'(ack0_cnt - a0), 64'd0);

        // watchdog timeout on port 0, then a stray ack
        a0 = ack0_cnt; tc = to_cnt;
        m0_req = 1'b1; m0_addr = 64'h123;
        ticks(1 + TO - 1);                       // grant cycle + 7 busy cycles
        chk("to_not_yet", 64'(to_cnt - tc), 64'd0);
        ticks(1);                                // 8th busy cycle
        m0_req = 1'b0;
        chk("to_pulse", 64'(to_cnt - tc), 64'd1);
        chk("to_ack0", 64'(ack0_cnt - a0), 64'd1);
        chk("to_rdata0", last_rd0, 64'd0);
        ticks(1);
        dc_ack = 1'b1; dc_rdata = 64'hFEED;
        ticks(1);
        dc_ack = 1'b0;
        chk("stray_ack0", 64'(ack0_cnt - a0), 64'd1);

        // reset while port 1 busy
        a1 = ack1_cnt;
        m1_req = 1'b1; m1_addr = 64'h999;
        ticks(2);
        rst = 1'b0;
        ticks(1);
        rst = 1'b1; m1_req = 1'b0;
        chk("rst_owner", o_owner, 64'd0);
        chk("rst_req", o_dcache_req, 64'd0);
        dc_ack = 1'b1; dc_rdata = 64'hCAFE;
        ticks(1);
        dc_ack = 1'b0;
        chk("rst_no_ack1", 64'(ack1_cnt - a1), 64'd0);
        m0_req = 1'b1; m0_addr = 64'h2000;
        ticks(1);
        chk("post_rst_owner", o_owner, 64'd1);
        dc_ack = 1'b1; dc_rdata = 64'h3030;
        ticks(1);
        m0_req = 1'b0; dc_ack = 1'b0;
        ticks(1);

        // ack and timeout in the same cycle: ack wins
        a0 = ack0_cnt; tc = to_cnt;
        m0_req = 1'b1;
        ticks(TO);                               // grant + 7 busy cycles without ack
        dc_ack = 1'b1; dc_rdata = 64'hABCD_0000_1234;
        ticks(1);
        m0_req = 1'b0; dc_ack = 1'b0;
        ticks(1);
        chk("col_ack0", 64'(ack0_cnt - a0), 64'd1);
        chk("col_rdata", last_rd0, 64'hABCD_0000_1234);
        chk("col_no_to", 64'(to_cnt - tc), 64'd0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 63) != 0);
            dc_ack = ($urandom_range(0, 3) == 0);
            dc_rdata = {$urandom, $urandom};
            m0_addr = {$urandom, $urandom}; m0_op = 1'($urandom); m0_bytes = 4'($urandom);
            m0_wdata = {$urandom, $urandom};
            m1_addr = {$urandom, $urandom}; m1_op = 1'($urandom); m1_bytes = 4'($urandom);
            m1_wdata = {$urandom, $urandom};
            if (saw_ack0) m0_req = ($urandom_range(0, 3) == 0);
            else if (!m0_req) m0_req = ($urandom_range(0, 2) == 0);
            if (saw_ack1) m1_req = ($urandom_range(0, 3) == 0);
            else if (!m1_req) m1_req = ($urandom_range(0, 2) == 0);
            ticks(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
